// File: rtl/piece_rotate_commit.sv
// Rotation-commit engine: probes four rotated squares against bounds and board, commits only if all legal.
// Latency: done pulses 5 cycles after the rot_req edge; piece registers update one cycle later.
// Backpressure: rot_req ignored while busy; load always wins and aborts any rotation in flight.
module piece_rotate_commit #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        load,
    input  logic [2:0]  load_shape,
    input  logic [15:0] load_x,
    input  logic [19:0] load_y,
    input  logic        rot_req,
    output logic [2:0]  lk_shape,
    output logic [1:0]  lk_orient,
    output logic [1:0]  lk_sq,
    input  logic [2:0]  lk_dx,
    input  logic [2:0]  lk_dy,
    input  logic [1:0]  lk_orient_next,
    output logic        brd_rd_en,
    output logic [3:0]  brd_rd_x,
    output logic [4:0]  brd_rd_y,
    input  logic        brd_occ,
    output logic [15:0] piece_x,
    output logic [19:0] piece_y,
    output logic [2:0]  piece_shape,
    output logic [1:0]  piece_orient,
    output logic        busy,
    output logic        done,
    output logic        accepted
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PROBE0 = 3'd1,
        PROBE1 = 3'd2,
        PROBE2 = 3'd3,
        PROBE3 = 3'd4,
        WAIT   = 3'd5,
        FINISH = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] piece_x_q, piece_x_d;
    logic [19:0] piece_y_q, piece_y_d;
    logic [2:0]  shape_q, shape_d;
    logic [1:0]  orient_q, orient_d;
    logic [15:0] cand_x_q, cand_x_d;
    logic [19:0] cand_y_q, cand_y_d;
    logic [1:0]  orient_nxt_q, orient_nxt_d;
    logic        collide_q, collide_d;
    logic        rd_en_q, rd_en_d;

    logic [1:0]        sq;
    logic signed [5:0] cx, cy;
    logic              oob;

    // Probe states are consecutive, so the square index falls out of the state encoding.
    assign sq  = 2'(state_q - PROBE0);
    assign cx  = $signed({2'b00, piece_x_q[4*sq +: 4]}) + $signed({{3{lk_dx[2]}}, lk_dx});
    assign cy  = $signed({1'b0, piece_y_q[5*sq +: 5]}) + $signed({{3{lk_dy[2]}}, lk_dy});
    assign oob = cx[5] || (cx[4:0] >= 5'(BOARD_W)) || cy[5] || (cy[4:0] >= 5'(BOARD_H));

    always_comb begin
        state_d      = state_q;
        piece_x_d    = piece_x_q;
        piece_y_d    = piece_y_q;
        shape_d      = shape_q;
        orient_d     = orient_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        orient_nxt_d = orient_nxt_q;
        collide_d    = collide_q;
        rd_en_d      = 1'b0;
        lk_sq        = 2'd0;
        brd_rd_en    = 1'b0;
        brd_rd_x     = 4'd0;
        brd_rd_y     = 5'd0;
        done         = 1'b0;
        accepted     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rot_req) begin
                    collide_d = 1'b0;
                    state_d   = PROBE0;
                end
            end
            PROBE0, PROBE1, PROBE2, PROBE3: begin
                lk_sq = sq;
                if (oob) begin
                    collide_d = 1'b1;
                end else begin
                    brd_rd_en = 1'b1;
                    brd_rd_x  = cx[3:0];
                    brd_rd_y  = cy[4:0];
                end
                cand_x_d[4*sq +: 4] = cx[3:0];
                cand_y_d[5*sq +: 5] = cy[4:0];
                if (state_q == PROBE0) begin
                    orient_nxt_d = lk_orient_next;
                end else if (rd_en_q && brd_occ) begin
                    collide_d = 1'b1;
                end
                rd_en_d = brd_rd_en;
                state_d = state_t'(state_q + 3'd1);
            end
            WAIT: begin
                if (rd_en_q && brd_occ) begin
                    collide_d = 1'b1;
                end
                state_d = FINISH;
            end
            FINISH: begin
                done     = 1'b1;
                accepted = ~collide_q;
                if (!collide_q) begin
                    piece_x_d = cand_x_q;
                    piece_y_d = cand_y_q;
                    orient_d  = orient_nxt_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A load discards any rotation in progress, including its commit and done pulse.
        if (load) begin
            state_d   = IDLE;
            piece_x_d = load_x;
            piece_y_d = load_y;
            shape_d   = load_shape;
            orient_d  = 2'd0;
            rd_en_d   = 1'b0;
            brd_rd_en = 1'b0;
            done      = 1'b0;
            accepted  = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            piece_x_q    <= '0;
            piece_y_q    <= '0;
            shape_q      <= '0;
            orient_q     <= '0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            orient_nxt_q <= '0;
            collide_q    <= 1'b0;
            rd_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            piece_x_q    <= piece_x_d;
            piece_y_q    <= piece_y_d;
            shape_q      <= shape_d;
            orient_q     <= orient_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            orient_nxt_q <= orient_nxt_d;
            collide_q    <= collide_d;
            rd_en_q      <= rd_en_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign lk_shape     = shape_q;
    assign lk_orient    = orient_q;
    assign piece_x      = piece_x_q;
    assign piece_y      = piece_y_q;
    assign piece_shape  = shape_q;
    assign piece_orient = orient_q;

endmodule
